// File: rtl/xbar_port_arbiter.sv
// Three-requester round-robin arbiter in front of a single peripheral port.
// Optional BUSY watchdog enabled by defining XBAR_ARB_TIMEOUT_EN.
module xbar_port_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [2:0]           req_i,
    input  logic [2:0]           we_i,
    input  logic [2:0][AW-1:0]   addr_i,
    input  logic [2:0][DW-1:0]   wdata_i,
    output logic [2:0]           gnt_o,
    output logic [2:0]           err_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 p_req_o,
    output logic                 p_we_o,
    output logic [AW-1:0]        p_addr_o,
    output logic [DW-1:0]        p_wdata_o,
    input  logic                 p_ready_i,
    input  logic [DW-1:0]        p_rdata_i
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;

    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;
    logic [1:0] idx;
    logic       timeout;

    logic          p_req_d;
    logic [2:0]    gnt_d;
    logic [2:0]    err_d;
    logic [DW-1:0] rdata_d;

    function automatic logic [1:0] wrap_inc(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] x);
        return 3'b001 << x;
    endfunction

    // Scan ptr, ptr+1, ptr+2 (mod 3) for the first pending requester.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = wrap_inc(cand);
        end
    end

`ifdef XBAR_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;

    assign timeout = (state_q == BUSY) && !p_ready_i &&
                     (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (!p_ready_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        idx     = pick;
        p_req_d = 1'b0;
        gnt_d   = 3'b000;
        err_d   = 3'b000;
        rdata_d = p_rdata_i;
        unique case (state_q)
            IDLE: begin
                idx = pick;
                if (found) begin
                    p_req_d = 1'b1;
                    if (p_ready_i) begin
                        gnt_d = onehot(pick);
                        ptr_d = wrap_inc(pick);
                    end else begin
                        sel_d   = pick;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                idx     = sel_q;
                p_req_d = 1'b1;
                if (p_ready_i) begin
                    gnt_d   = onehot(sel_q);
                    ptr_d   = wrap_inc(sel_q);
                    state_d = IDLE;
                end else if (timeout) begin
                    // Abandon the stuck access and report it to the owner.
                    p_req_d = 1'b0;
                    gnt_d   = onehot(sel_q);
                    err_d   = onehot(sel_q);
                    rdata_d = '0;
                    ptr_d   = wrap_inc(sel_q);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign p_we_o    = we_i[idx];
    assign p_addr_o  = addr_i[idx];
    assign p_wdata_o = wdata_i[idx];
    assign rdata_o   = rdata_d;

    // Outputs are held quiet for the whole reset window, not just at the edge.
    assign p_req_o = rst_ni & p_req_d;
    assign gnt_o   = rst_ni ? gnt_d : 3'b000;
`ifdef XBAR_ARB_TIMEOUT_EN
    assign err_o   = rst_ni ? err_d : 3'b000;
`else
    assign err_o   = 3'b000;
`endif

endmodule

// File: tb/tb_xbar_port_arbiter.sv
// Randomised and directed bench for xbar_port_arbiter against a
// queue-free round-robin reference model.
module tb_xbar_port_arbiter;

    localparam int TMO = 4;
`ifdef XBAR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [2:0]        req_i = '0;
    logic [2:0]        we_i = '0;
    logic [2:0][31:0]  addr_i = '0;
    logic [2:0][31:0]  wdata_i = '0;
    logic [2:0]        gnt_o;
    logic [2:0]        err_o;
    logic [31:0]       rdata_o;
    logic              p_req_o;
    logic              p_we_o;
    logic [31:0]       p_addr_o;
    logic [31:0]       p_wdata_o;
    logic              p_ready_i = 1'b0;
    logic [31:0]       p_rdata_i = '0;

    xbar_port_arbiter #(
        .AW(32),
        .DW(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_i(req_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .gnt_o(gnt_o),
        .err_o(err_o),
        .rdata_o(rdata_o),
        .p_req_o(p_req_o),
        .p_we_o(p_we_o),
        .p_addr_o(p_addr_o),
        .p_wdata_o(p_wdata_o),
        .p_ready_i(p_ready_i),
        .p_rdata_i(p_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: next priority, locked owner (-1 none),
    // and number of stalled cycles spent waiting on the owner.
    int m_ptr = 0;
    int m_lock = -1;
    int m_wait = 0;

    int         e_owner;
    logic       e_req;
    logic [2:0] e_gnt;
    logic [2:0] e_err;
    logic [31:0] e_rdata;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_lock = -1;
        m_wait = 0;
    endtask

    task automatic model_check();
        bit to;
        e_owner = -1;
        e_req   = 1'b0;
        e_gnt   = 3'b000;
        e_err   = 3'b000;
        e_rdata = p_rdata_i;
        if (m_lock >= 0) begin
            e_owner = m_lock;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (e_owner < 0 && req_i[(m_ptr + k) % 3])
                    e_owner = (m_ptr + k) % 3;
            end
        end
        if (e_owner >= 0) begin
            to = TO_EN && (m_lock >= 0) && !p_ready_i &&
                 (m_wait + 1 == TMO);
            e_req = !to;
            if (p_ready_i || to) e_gnt = 3'b001 << e_owner;
            if (to) begin
                e_err   = 3'b001 << e_owner;
                e_rdata = '0;
            end
        end
        chk("p_req", 64'(p_req_o), 64'(e_req));
        chk("gnt", 64'(gnt_o), 64'(e_gnt));
        chk("err", 64'(err_o), 64'(e_err));
        if (e_req) begin
            chk("p_we", 64'(p_we_o), 64'(we_i[e_owner]));
            chk("p_addr", 64'(p_addr_o), 64'(addr_i[e_owner]));
            chk("p_wdata", 64'(p_wdata_o), 64'(wdata_i[e_owner]));
        end
        if (e_gnt != 3'b000)
            chk("rdata", 64'(rdata_o), 64'(e_rdata));
    endtask

    task automatic model_update();
        if (e_gnt != 3'b000) begin
            m_ptr  = (e_owner + 1) % 3;
            m_lock = -1;
            m_wait = 0;
            req_i[e_owner] = 1'b0;
        end else if (e_owner >= 0) begin
            if (m_lock < 0) begin
                m_lock = e_owner;
                m_wait = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic step(input logic [2:0] r, input logic rdy,
                        input logic [31:0] rd);
        req_i     = r;
        p_ready_i = rdy;
        p_rdata_i = rd;
        @(negedge clk_i);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
        model_update();
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        req_i     = 3'b111;
        p_ready_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        chk("rst_p_req", 64'(p_req_o), 64'h0);
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        req_i     = 3'b000;
        p_ready_i = 1'b0;
    endtask

    initial begin
        logic [2:0] r;
        for (int j = 0; j < 3; j++) begin
            addr_i[j]  = 32'h1000_0000 + 32'(j) * 32'h10;
            wdata_i[j] = 32'hA000_0000 + 32'(j);
            we_i[j]    = j[0];
        end

        // Zero-latency single grant, then ptr=1 gives requester 1 priority.
        do_reset();
        step(3'b001, 1'b1, 32'h0);
        chk("z_p_req", 64'(p_req_o), 64'h1);
        chk("z_p_addr", 64'(p_addr_o), 64'h1000_0000);
        chk("z_gnt", 64'(gnt_o), 64'h1);
        adv();
        step(3'b111, 1'b1, 32'h0);
        chk("z_ptr1", 64'(gnt_o), 64'h2);
        adv();

        // Round-robin rotation with everyone requesting.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(3'b111, 1'b1, 32'h0);
            chk("rr_gnt", 64'(gnt_o), 64'(c == 1 ? 3'b010 :
                                         c == 2 ? 3'b100 : 3'b001));
            adv();
        end

        // Locked owner survives a competing request.
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            step(c >= 2 ? 3'b011 : 3'b010, c == 4, 32'h0);
            chk("lock_addr", 64'(p_addr_o), 64'h1000_0010);
            chk("lock_gnt", 64'(gnt_o), 64'(c == 4 ? 3'b010 : 3'b000));
            adv();
        end
        step(3'b001, 1'b1, 32'h0);
        chk("lock_next", 64'(gnt_o), 64'h1);
        adv();

        // Read data passthrough.
        step(3'b100, 1'b1, 32'hDEAD_BEEF);
        chk("rd_gnt", 64'(gnt_o), 64'h4);
        chk("rd_data", 64'(rdata_o), 64'hDEAD_BEEF);
        adv();

        // Reset mid-BUSY: no grant afterwards and ptr back to 0.
        do_reset();
        step(3'b001, 1'b1, 32'h0);
        adv();
        step(3'b100, 1'b0, 32'h0);
        adv();
        rst_ni = 1'b0;
        #1;
        chk("mr_p_req", 64'(p_req_o), 64'h0);
        chk("mr_gnt", 64'(gnt_o), 64'h0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(3'b000, 1'b1, 32'h0);
        chk("mr_nognt", 64'(gnt_o), 64'h0);
        adv();
        step(3'b011, 1'b1, 32'h0);
        chk("mr_ptr0", 64'(gnt_o), 64'h1);
        adv();

`ifdef XBAR_ARB_TIMEOUT_EN
        // Watchdog fires on the 4th BUSY cycle; a late ready still wins.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            step(3'b100, 1'b0, 32'h0);
            adv();
            for (int c = 1; c <= 3; c++) begin
                step(3'b100, 1'b0, 32'h0);
                chk("to_wait", 64'(gnt_o), 64'h0);
                adv();
            end
            step(3'b100, pass == 1, 32'hDEAD_BEEF);
            chk("to_gnt", 64'(gnt_o), 64'h4);
            chk("to_err", 64'(err_o), 64'(pass == 1 ? 3'b000 : 3'b100));
            chk("to_rdata", 64'(rdata_o),
                64'(pass == 1 ? 32'hDEAD_BEEF : 32'h0));
            chk("to_p_req", 64'(p_req_o), 64'(pass == 1));
            adv();
        end
`endif

        // Randomised traffic with requests held until granted.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r = req_i;
            for (int j = 0; j < 3; j++) begin
                if (!r[j] && $urandom_range(2) == 0) begin
                    r[j]       = 1'b1;
                    addr_i[j]  = $urandom;
                    wdata_i[j] = $urandom;
                    we_i[j]    = 1'($urandom);
                end
            end
            step(r, $urandom_range(2) == 0, $urandom);
            adv();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/xbar_port_arbiter.md
XBAR_PORT_ARBITER -- requirements
Module: xbar_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning BUSY cycles before abort; legal range 1..65535.
REQ-004 SHALL have clk_i  input  1  clock; all state on rising edge.
REQ-005 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have req_i  input  3  per-requester request; held high until that requester's gnt_o.
REQ-007 SHALL have we_i  input  3  per-requester write enable.
REQ-008 SHALL have addr_i  input  3xAW  per-requester address.
REQ-009 SHALL have wdata_i  input  3xDW  per-requester write data.
REQ-010 SHALL have gnt_o  output  3  one-hot completion pulse to the served requester.
REQ-011 SHALL have err_o  output  3  one-hot abort flag, valid with gnt_o.
REQ-012 SHALL have rdata_o  output  DW  read data, valid in a gnt_o cycle.
REQ-013 SHALL have p_req_o, p_we_o, p_addr_o, p_wdata_o  outputs  1/1/AW/DW  peripheral request and fields.
REQ-014 SHALL have p_ready_i  input  1  peripheral completes the current request this cycle.
REQ-015 SHALL have p_rdata_i  input  DW  peripheral read data.

Function
REQ-016 SHALL implement FSM states IDLE and BUSY, plus a 2-bit round-robin pointer ptr (values 0..2) and a 2-bit locked index sel_q.
REQ-017 In IDLE, the selected requester SHALL be the first asserted req_i scanning ptr, ptr+1, ptr+2 (mod 3).
REQ-018 In IDLE with any req_i asserted, p_req_o SHALL be 1 in the same cycle, with p_we_o/p_addr_o/p_wdata_o taken from the selected requester (zero latency).
REQ-019 In IDLE with p_ready_i=1 and a selection present, the block SHALL pulse gnt_o[sel], set ptr=(sel+1) mod 3, and stay in IDLE.
REQ-020 In IDLE with p_ready_i=0 and a selection present, the block SHALL latch sel_q=sel and enter BUSY.
REQ-021 In BUSY, the block SHALL drive p_req_o=1 with fields from requester sel_q regardless of other req_i changes.
REQ-022 In BUSY with p_ready_i=1, the block SHALL pulse gnt_o[sel_q], set ptr=(sel_q+1) mod 3, and return to IDLE.
REQ-023 With no req_i asserted in IDLE, p_req_o SHALL be 0, gnt_o SHALL be 0, and ptr SHALL hold.
REQ-024 rdata_o SHALL equal p_rdata_i in every normal gnt_o cycle.
REQ-025 gnt_o and err_o SHALL each have at most one bit set, and no bit set outside a completion cycle.
REQ-026 A requester deasserting req_i while BUSY is illegal; the block SHALL still finish the locked transaction.
REQ-027 Back-to-back transactions SHALL be supported: a new selection in IDLE is allowed the cycle after a BUSY completion.

Reset
REQ-028 Asserting rst_ni low SHALL force IDLE, ptr=0 and sel_q=0 immediately, including mid-transaction; no gnt_o is issued for an aborted transaction.
REQ-029 While in reset, p_req_o, gnt_o and err_o SHALL be 0, and the timeout counter (if present) SHALL be 0.

Configuration
REQ-030 Macro XBAR_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without p_ready_i.
REQ-031 With the macro defined, when the counter reaches TIMEOUT_CYCLES, the block SHALL pulse gnt_o[sel_q] and err_o[sel_q], force rdata_o=0, deassert p_req_o that cycle, advance ptr, and return to IDLE.
REQ-032 With the macro defined, p_ready_i=1 in the timeout cycle SHALL win: normal completion, err_o=0.
REQ-033 Macro XBAR_ARB_TIMEOUT_EN undefined: no counter SHALL exist, err_o SHALL be tied 0, and BUSY SHALL wait indefinitely for p_ready_i.

Verification
REQ-034 Reset, then req_i=3'b001, p_ready_i=1 in the same cycle -> p_req_o=1 and p_addr_o=addr_i[0] that cycle, gnt_o=3'b001 that cycle, next-cycle ptr=1.
REQ-035 req_i=3'b111 held, p_ready_i=1 every cycle -> gnt_o sequence 001, 010, 100, 001.
REQ-036 req_i=3'b010, p_ready_i low for 3 cycles, req_i[0] raised in cycle 2 -> p_addr_o stays addr_i[1] for 4 cycles, gnt_o=3'b010 in cycle 4, then requester 0 is served.
REQ-037 Read with p_rdata_i=32'hDEADBEEF when p_ready_i=1 -> rdata_o=32'hDEADBEEF in the gnt_o cycle.
REQ-038 XBAR_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, req_i=3'b100, p_ready_i=0 -> gnt_o=err_o=3'b100 on the 4th BUSY cycle and rdata_o=0; repeat with p_ready_i=1 on that cycle -> err_o=0.
REQ-039 rst_ni pulsed low during BUSY -> p_req_o=0 immediately, no gnt_o, ptr=0 after release.
